// File: rtl/mask_pkg.sv
// rtl/mask_pkg.sv - shared FSM state type and default widths for mask_bbox
package mask_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        ACCUM   = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    localparam int X_W_DEF     = 12;
    localparam int Y_W_DEF     = 12;
    localparam int CNT_W_DEF   = 22;
    localparam int MIN_PIX_DEF = 16;

endpackage

// File: rtl/mask_bbox_if.sv
// rtl/mask_bbox_if.sv - threshold-stage video input and bounding-box result bundle
interface mask_bbox_if
    import mask_pkg::*;
#(
    parameter int X_W   = X_W_DEF,
    parameter int Y_W   = Y_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic             thr_data;
    logic             thr_de;
    logic             thr_hs;
    logic             thr_vs;
    logic [X_W-1:0]   box_x_min;
    logic [X_W-1:0]   box_x_max;
    logic [Y_W-1:0]   box_y_min;
    logic [Y_W-1:0]   box_y_max;
    logic [CNT_W-1:0] box_cnt;
    logic             box_found;
    logic             box_valid;

    modport master (
        output thr_data, thr_de, thr_hs, thr_vs,
        input  box_x_min, box_x_max, box_y_min, box_y_max, box_cnt, box_found, box_valid
    );

    modport slave (
        input  thr_data, thr_de, thr_hs, thr_vs,
        output box_x_min, box_x_max, box_y_min, box_y_max, box_cnt, box_found, box_valid
    );

endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - input register stage with de trailing and vs leading edge detect
module sync_edge #(
    parameter bit VS_POL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic de_i,
    input  logic vs_i,
    output logic de_o,
    output logic de_fall_o,
    output logic vs_lead_o
);

    logic vs_act;
    logic de_q;
    logic de_prev_q;
    logic vs_q;
    logic vs_prev_q;

    // vs is normalised to active-high so a cleared register means "not in vsync"
    assign vs_act = (vs_i == VS_POL);

    // S1 register plus one-cycle history; de is masked during vsync so video
    // enables inside the sync interval never move the counters or accumulators
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_q      <= 1'b0;
            de_prev_q <= 1'b0;
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            de_q      <= de_i & ~vs_act;
            de_prev_q <= de_q;
            vs_q      <= vs_act;
            vs_prev_q <= vs_q;
        end
    end

    assign de_o      = de_q;
    assign de_fall_o = de_prev_q & ~de_q;
    assign vs_lead_o = vs_q & ~vs_prev_q;

endmodule

// File: rtl/mask_bbox.sv
// rtl/mask_bbox.sv - per-frame bounding box and pixel count of a binary foreground mask
module mask_bbox
    import mask_pkg::*;
#(
    parameter int X_W     = X_W_DEF,
    parameter int Y_W     = Y_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MIN_PIX = MIN_PIX_DEF,
    parameter bit VS_POL  = 1'b1
) (
    input logic        clk,
    input logic        rst_n,
    mask_bbox_if.slave bus
);

    localparam int CMP_W = (CNT_W > 32) ? CNT_W : 32;

    logic de_s1, de_fall, vs_lead, data_q, pix_hit;
    state_t state_q, state_d;
    logic [X_W-1:0]   x_q, x_d, min_x_q, min_x_d, max_x_q, max_x_d, box_x_min_q, box_x_max_q;
    logic [Y_W-1:0]   y_q, y_d, min_y_q, min_y_d, max_y_q, max_y_d, box_y_min_q, box_y_max_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, box_cnt_q;
    logic             box_found_q, box_valid_q;

    sync_edge #(.VS_POL(VS_POL)) u_sync_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .de_i      (bus.thr_de),
        .vs_i      (bus.thr_vs),
        .de_o      (de_s1),
        .de_fall_o (de_fall),
        .vs_lead_o (vs_lead)
    );

    // S1 copy of the mask bit, aligned with the registered de/vs
    always_ff @(posedge clk) begin
        if (!rst_n) data_q <= 1'b0;
        else        data_q <= bus.thr_data;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= SYNC;
        else        state_q <= state_d;
    end

    // FSM next state: the first frame edge only arms accumulation
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (vs_lead) state_d = ACCUM;
            ACCUM:   if (vs_lead) state_d = PUBLISH;
            PUBLISH: state_d = ACCUM;
            default: state_d = SYNC;
        endcase
    end

    // Pixel coordinates of the current S1 sample, both saturating
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (de_s1) begin
            if (x_q != '1) x_d = x_q + 1'b1;
        end else if (de_fall) begin
            x_d = '0;
        end
        if (vs_lead)                   y_d = '0;
        else if (de_fall && y_q != '1) y_d = y_q + 1'b1;
    end

    // The frame-edge cycle is excluded; accumulators freeze there so PUBLISH can
    // copy them, and re-initialise whenever not accumulating (SYNC and PUBLISH)
    assign pix_hit = de_s1 & data_q & (state_q == ACCUM) & ~vs_lead;

    // Accumulator next state
    always_comb begin
        min_x_d = min_x_q;
        max_x_d = max_x_q;
        min_y_d = min_y_q;
        max_y_d = max_y_q;
        cnt_d   = cnt_q;
        if (state_q != ACCUM) begin
            min_x_d = '1;
            max_x_d = '0;
            min_y_d = '1;
            max_y_d = '0;
            cnt_d   = '0;
        end else if (pix_hit) begin
            if (x_q < min_x_q) min_x_d = x_q;
            if (x_q > max_x_q) max_x_d = x_q;
            if (y_q < min_y_q) min_y_d = y_q;
            if (y_q > max_y_q) max_y_d = y_q;
            if (cnt_q != '1)   cnt_d   = cnt_q + 1'b1;
        end
    end

    // Counter and accumulator registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            min_x_q <= '0;
            max_x_q <= '0;
            min_y_q <= '0;
            max_y_q <= '0;
            cnt_q   <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            min_x_q <= min_x_d;
            max_x_q <= max_x_d;
            min_y_q <= min_y_d;
            max_y_q <= max_y_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result registers load once per frame in PUBLISH and hold otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            box_x_min_q <= '0;
            box_x_max_q <= '0;
            box_y_min_q <= '0;
            box_y_max_q <= '0;
            box_cnt_q   <= '0;
            box_found_q <= 1'b0;
            box_valid_q <= 1'b0;
        end else begin
            box_valid_q <= (state_q == PUBLISH);
            if (state_q == PUBLISH) begin
                box_x_min_q <= min_x_q;
                box_x_max_q <= max_x_q;
                box_y_min_q <= min_y_q;
                box_y_max_q <= max_y_q;
                box_cnt_q   <= cnt_q;
                box_found_q <= (CMP_W'(cnt_q) >= CMP_W'(MIN_PIX));
            end
        end
    end

    assign bus.box_x_min = box_x_min_q;
    assign bus.box_x_max = box_x_max_q;
    assign bus.box_y_min = box_y_min_q;
    assign bus.box_y_max = box_y_max_q;
    assign bus.box_cnt   = box_cnt_q;
    assign bus.box_found = box_found_q;
    assign bus.box_valid = box_valid_q;

endmodule

// File: doc/mask_bbox.md
MASK_BBOX -- requirements
Module: mask_bbox

Interface
REQ-001 Parameter X_W, default 12, pixel-column counter and box-coordinate width.
REQ-002 Parameter Y_W, default 12, line counter and box-coordinate width.
REQ-003 Parameter CNT_W, default 22, foreground pixel-count width.
REQ-004 Parameter MIN_PIX, default 16, minimum foreground pixels per frame for box_found.
REQ-005 Parameter VS_POL, default 1'b1, active level of thr_vs (1 = active-high).
REQ-006 clk  input  1  sole clock; all logic on posedge.
REQ-007 rst_n  input  1  reset, synchronous and active-low.
REQ-008 thr_data  input  1  binary mask pixel from the threshold stage, valid when thr_de=1.
REQ-009 thr_de  input  1  active-video data enable.
REQ-010 thr_hs  input  1  line sync; pass-through only.
REQ-011 thr_vs  input  1  frame sync; its leading edge (toward VS_POL) marks frame boundary.
REQ-012 box_x_min / box_x_max  output  X_W each  column bounds of foreground in last completed frame.
REQ-013 box_y_min / box_y_max  output  Y_W each  line bounds of foreground in last completed frame.
REQ-014 box_cnt  output  CNT_W  foreground pixel count of last completed frame, saturating.
REQ-015 box_found  output  1  box_cnt >= MIN_PIX for last completed frame.
REQ-016 box_valid  output  1  one-cycle strobe when all box_* outputs update.

Function
REQ-017 Inputs SHALL be registered once (stage S1); all decisions use S1 values.
REQ-018 Column counter x SHALL be 0 on first de cycle of a line, +1 per de cycle, reset to 0 on de falling edge; saturates at 2^X_W-1.
REQ-019 Line counter y SHALL increment on each de falling edge, reset to 0 on frame-boundary edge; saturates at 2^Y_W-1.
REQ-020 FSM states: SYNC (after reset, wait first frame edge), ACCUM (gathering), PUBLISH (one cycle).
REQ-021 SYNC->ACCUM on first frame edge; no box_valid SHALL be produced for the partial frame preceding it.
REQ-022 ACCUM->PUBLISH on frame edge; PUBLISH->ACCUM unconditionally next cycle.
REQ-023 In ACCUM, each cycle with de=1 and data=1 SHALL update min_x/max_x/min_y/max_y with current x,y and increment count (saturating at 2^CNT_W-1).
REQ-024 Accumulators SHALL be re-initialised at frame edge: min_* = all-ones, max_* = 0, count = 0; a pixel in the edge cycle itself is ignored.
REQ-025 In PUBLISH, box_* SHALL load from accumulators and box_valid=1 for exactly that cycle; box_valid SHALL assert exactly 2 clk edges after the edge at which thr_vs first samples active.
REQ-026 If count=0 at publish, box_* SHALL output min=all-ones, max=0, box_cnt=0, box_found=0.
REQ-027 de=1 while vs active SHALL be ignored (no accumulation, counters unchanged).
REQ-028 box_* SHALL hold between strobes.

Reset
REQ-029 rst_n=0 at a clk edge SHALL force: FSM=SYNC, counters/accumulators cleared, S1 regs 0, box_x_min/box_x_max/box_y_min/box_y_max/box_cnt=0, box_found=0, box_valid=0.
REQ-030 Reset mid-frame SHALL discard the frame; the next box_valid requires a fresh SYNC->ACCUM->PUBLISH cycle.

Structure
REQ-031 Shared package mask_pkg SHALL hold the FSM state enum (SYNC, ACCUM, PUBLISH) and default width constants.
REQ-032 One sub-module, sync_edge (register + leading/trailing edge detect for de and vs), SHALL be instantiated; remaining logic is flat.

Verification
REQ-033 8x4 frame, all mask 0, two frames -> one box_valid after 2nd frame edge only, box_cnt=0, box_found=0, min=all-ones, max=0.
REQ-034 8x4 frame, mask 1 at (x=2,y=1),(5,3) -> box_x 2..5, box_y 1..3, box_cnt=2, box_found=0 (MIN_PIX=16).
REQ-035 16x16 frame, full mask 1 -> box 0..15/0..15, box_cnt=256, box_found=1, box_valid exactly 2 cycles after vs assertion.
REQ-036 rst_n pulsed low mid-frame with mask 1 present -> outputs 0 next edge, no box_valid until one complete frame after next vs edge.
REQ-037 CNT_W=4, 20 mask pixels -> box_cnt=15 (saturated), box_found per MIN_PIX=8 =1.
REQ-038 VS_POL=0, de asserted during vs active with mask 1 -> those pixels excluded from box and count.
